bklt_pwm_ctrl: RTL and testbench
================================

# bklt_pwm_ctrl

Parametrised backlight PWM controller for the gMUX bypass design. It holds the period (max backlight) and duty (backlight) registers behind the existing LPC peripheral's byte read/write strobes and applies new values only at a PWM period boundary, so the output has no glitches. It supports a linear fade toward the target duty and a wrap-around brightness-level step driven by a single pre-filtered button pulse. It generalises the fixed 17-bit/200 Hz backlight path.

## Interface
- CNT_W, 24: width of the PWM counter, the active period and the duty values (8..32).
- LEVEL_W, 4: width of the button level index; NUM_LEVELS = 2**LEVEL_W.
- PERIOD_RST, 142711: reset period; one PWM cycle lasts PERIOD_RST+1 clocks.
- DUTY_RST, 49949: reset duty, applied to both target and active duty.
- LEVEL_RST, 11: reset level index (1..NUM_LEVELS-1).
- RAMP_STEP, 256: largest change to the active duty per PWM period.
- LPC_CLK33M_GMUX  in  1  33 MHz clock; every register updates on the rising edge.
- LPCPLUS_RESET_L  in  1  asynchronous, active-low reset.
- reg_wr_en  in  1  one-cycle LPC write strobe.
- reg_rd_en  in  1  one-cycle LPC read strobe.
- reg_addr  in  16  LPC I/O address.
- reg_wdata  in  8  write byte.
- reg_rdata  out  8  read byte, registered; reset value 0.
- btn_step  in  1  one-cycle button event, already debounced upstream.
- pwm_out  out  1  LCD_BKLT_PWM drive; reset value 0.
- ramp_busy  out  1  high while active duty differs from target duty; reset value 0.

## Operation
- Register map (byte-wide, little-endian):
  - 0x0704/0x0705/0x0706: version 1/9/37.
  - 0x0770..0x0773: period.
  - 0x0774..0x0777: target duty.
  - 0x0778: status. bit0 = ramp_busy, bits[LEVEL_W:1] = level, remaining bits 0.
  - Any other address reads 0.
- Writes to bytes 0..2 only fill a 32-bit staging register (one each for period and duty).
- A write to byte 3 (0x0773 or 0x0777) commits the staging value plus that byte. Bits at or above CNT_W are dropped. Target is updated the next cycle.
- Reads of period and duty return the committed period / committed target duty, not the staging value.
- Address 0x0778 is read-only; writes to it are ignored.
- Committed period becomes the active period at the next boundary.
- Counter runs 0..active period and wraps to 0. A boundary is the cycle where counter == active period.
- pwm_out = (counter < active duty), registered. Corner cases:
  - duty 0: output is always low.
  - duty > period: output is always high.
  - period 0: counter stays at 0 and every cycle is a boundary.
- At each boundary the active duty moves toward the target by min(RAMP_STEP, |target − duty|).
- btn_step behaviour:
  - level = level+1; when level is NUM_LEVELS−1, it wraps to 1 (level 0 is never selected by the button).
  - One cycle later, target = ((committed period + 1) × level) >> LEVEL_W. The product is held at full width and the result truncated to CNT_W.
  - If btn_step and a byte-3 duty commit happen in the same cycle, the LPC value wins. The level still advances.
- A byte-3 period commit does not rescale the target.
- Reset mid-period: the counter, staging registers and outputs return to their reset values at once. The counter restarts from 0.

## Timing
- Read latency is 1: reg_rdata is valid the cycle after reg_rd_en and holds until the next read.
- Byte-3 commit to target: 1 cycle. Target to active: at the next boundary, up to period+1 cycles.
- btn_step to target: 2 cycles.
- Active duty to pwm_out: 1 cycle. Both pwm_out and ramp_busy come straight from flops.
- reg_wr_en and reg_rd_en asserted together: both are honoured. Read data reflects the value before the write.

## Configuration
- BKLT_RAMP_EN defined: the fade behaves as described; ramp_busy can be high.
- BKLT_RAMP_EN undefined: at each boundary the active duty loads the target directly. RAMP_STEP is unused; ramp_busy is tied to 0; status bit0 reads 0.

## Structure
- Package bklt_pkg:
  - address constants 0x0704..0x0778;
  - version bytes;
  - a register-select enum (VER, PERIOD, DUTY, STATUS, NONE).
- Sub-module bklt_pwm_core:
  - counter, boundary detect, loading of active period and duty, ramp, pwm_out;
  - parametrised by CNT_W and RAMP_STEP.
- The top level holds the register decode, staging, commit, level and read mux.

## Test plan
- Reset → pwm_out high for 49949 of every 142712 cycles. Address 0x0774..0x0777 reads 0x1D,0xC3,0x00,0x00. Status reads level 11.
- Write duty 0x00001000 with fade off (macro undefined) → new duty appears exactly at the next boundary, not before; no truncated pulse.
- Write period 99, duty 50 with the macro on → active duty steps 256 per period to 50. ramp_busy falls on the boundary where duty equals 50.
- Pulse btn_step five times from level 11 → levels 12,13,14,15,1. At level 1 with period 99, target = 6.
- Write duty 200 with period 99 → pwm_out constantly high. Write duty 0 → pwm_out constantly low.
- btn_step in the same cycle as a 0x0777 write → target equals the LPC value and the level advances. Assert reset mid-period → pwm_out 0 at once and the counter restarts from 0.

Source files
------------

// File: rtl/bklt_pkg.sv
// rtl/bklt_pkg.sv - Register map constants, version bytes and register-select decode for the backlight PWM controller
package bklt_pkg;

    localparam logic [15:0] ADDR_VER0    = 16'h0704;
    localparam logic [15:0] ADDR_VER2    = 16'h0706;
    localparam logic [15:0] ADDR_PERIOD0 = 16'h0770;
    localparam logic [15:0] ADDR_PERIOD3 = 16'h0773;
    localparam logic [15:0] ADDR_DUTY0   = 16'h0774;
    localparam logic [15:0] ADDR_DUTY3   = 16'h0777;
    localparam logic [15:0] ADDR_STATUS  = 16'h0778;

    localparam logic [7:0] VER_MAJOR = 8'd1;
    localparam logic [7:0] VER_MINOR = 8'd9;
    localparam logic [7:0] VER_PATCH = 8'd37;

    typedef enum logic [2:0] {
        VER,
        PERIOD,
        DUTY,
        STATUS,
        NONE
    } reg_sel_t;

    function automatic reg_sel_t decode_addr(input logic [15:0] addr);
        reg_sel_t sel;
        sel = NONE;
        if (addr >= ADDR_VER0 && addr <= ADDR_VER2) begin
            sel = VER;
        end else if (addr >= ADDR_PERIOD0 && addr <= ADDR_PERIOD3) begin
            sel = PERIOD;
        end else if (addr >= ADDR_DUTY0 && addr <= ADDR_DUTY3) begin
            sel = DUTY;
        end else if (addr == ADDR_STATUS) begin
            sel = STATUS;
        end
        return sel;
    endfunction

endpackage

// File: rtl/bklt_pwm_core.sv
// rtl/bklt_pwm_core.sv - PWM counter, boundary-synchronous period/duty loading and fade; fade enabled by BKLT_RAMP_EN
module bklt_pwm_core
    import bklt_pkg::*;
#(
    parameter int          CNT_W      = 24,
    parameter int          RAMP_STEP  = 256,
    parameter int unsigned PERIOD_RST = 142711,
    parameter int unsigned DUTY_RST   = 49949
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] period_tgt,
    input  logic [CNT_W-1:0] duty_tgt,
    output logic             pwm_out,
    output logic             ramp_busy
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] duty_nxt;
    logic             boundary;

    assign boundary = (cnt == period_act);

`ifdef BKLT_RAMP_EN
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] step;
    logic             up;

    // Step is clamped to the remaining distance so the fade never overshoots.
    always_comb begin
        up       = (duty_tgt > duty_act);
        diff     = up ? (duty_tgt - duty_act) : (duty_act - duty_tgt);
        step     = ({1'b0, 32'(diff)} > 33'(RAMP_STEP)) ? CNT_W'(RAMP_STEP) : diff;
        duty_nxt = duty_act;
        if (boundary) begin
            duty_nxt = up ? (duty_act + step) : (duty_act - step);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_busy <= 1'b0;
        end else begin
            ramp_busy <= (duty_nxt != duty_tgt);
        end
    end
`else
    logic unused_ramp;

    always_comb begin
        duty_nxt = duty_act;
        if (boundary) begin
            duty_nxt = duty_tgt;
        end
    end

    assign ramp_busy   = 1'b0;
    assign unused_ramp = (RAMP_STEP != 0);
`endif

    // Period and duty only change when the counter wraps, so no pulse is ever cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            period_act <= CNT_W'(PERIOD_RST);
            duty_act   <= CNT_W'(DUTY_RST);
            pwm_out    <= 1'b0;
        end else begin
            if (boundary) begin
                cnt        <= '0;
                period_act <= period_tgt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            duty_act <= duty_nxt;
            pwm_out  <= (cnt < duty_act);
        end
    end

endmodule

// File: rtl/bklt_pwm_ctrl.sv
// rtl/bklt_pwm_ctrl.sv - Backlight PWM controller top: LPC byte registers, staging/commit, button levels; fade enabled by BKLT_RAMP_EN
module bklt_pwm_ctrl
    import bklt_pkg::*;
#(
    parameter int          CNT_W      = 24,
    parameter int          LEVEL_W    = 4,
    parameter int unsigned PERIOD_RST = 142711,
    parameter int unsigned DUTY_RST   = 49949,
    parameter int unsigned LEVEL_RST  = 11,
    parameter int          RAMP_STEP  = 256
) (
    input  logic        LPC_CLK33M_GMUX,
    input  logic        LPCPLUS_RESET_L,
    input  logic        reg_wr_en,
    input  logic        reg_rd_en,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    input  logic        btn_step,
    output logic        pwm_out,
    output logic        ramp_busy
);

    localparam int                 NUM_LEVELS = 2 ** LEVEL_W;
    localparam int                 PROD_W     = CNT_W + 1 + LEVEL_W;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(NUM_LEVELS - 1);

    reg_sel_t           sel;
    logic [1:0]         byte_idx;
    logic [23:0]        period_stage;
    logic [23:0]        duty_stage;
    logic [CNT_W-1:0]   period_cmt;
    logic [CNT_W-1:0]   duty_tgt;
    logic [CNT_W-1:0]   scaled;
    logic [LEVEL_W-1:0] level;
    logic               scale_pend;
    logic               period_fill;
    logic               period_commit;
    logic               duty_fill;
    logic               duty_commit;
    logic [PROD_W-1:0]  prod;
    logic [31:0]        period_rd;
    logic [31:0]        duty_rd;
    logic [7:0]         rd_byte;

    assign sel           = decode_addr(reg_addr);
    assign byte_idx      = reg_addr[1:0];
    assign period_fill   = reg_wr_en && (sel == PERIOD) && (byte_idx != 2'd3);
    assign period_commit = reg_wr_en && (sel == PERIOD) && (byte_idx == 2'd3);
    assign duty_fill     = reg_wr_en && (sel == DUTY) && (byte_idx != 2'd3);
    assign duty_commit   = reg_wr_en && (sel == DUTY) && (byte_idx == 2'd3);

    // Full-width product so a large period never overflows before the level shift.
    assign prod      = (PROD_W'(period_cmt) + PROD_W'(1)) * PROD_W'(level);
    assign scaled    = CNT_W'(prod >> LEVEL_W);
    assign period_rd = 32'(period_cmt);
    assign duty_rd   = 32'(duty_tgt);

    always_comb begin
        rd_byte = 8'h00;
        case (sel)
            VER: begin
                case (byte_idx)
                    2'd0:    rd_byte = VER_MAJOR;
                    2'd1:    rd_byte = VER_MINOR;
                    2'd2:    rd_byte = VER_PATCH;
                    default: rd_byte = 8'h00;
                endcase
            end
            PERIOD:  rd_byte = period_rd[{byte_idx, 3'b000} +: 8];
            DUTY:    rd_byte = duty_rd[{byte_idx, 3'b000} +: 8];
            STATUS:  rd_byte = 8'({level, ramp_busy});
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge LPC_CLK33M_GMUX or negedge LPCPLUS_RESET_L) begin
        if (!LPCPLUS_RESET_L) begin
            reg_rdata    <= 8'h00;
            period_stage <= '0;
            duty_stage   <= '0;
            period_cmt   <= CNT_W'(PERIOD_RST);
            duty_tgt     <= CNT_W'(DUTY_RST);
            level        <= LEVEL_W'(LEVEL_RST);
            scale_pend   <= 1'b0;
        end else begin
            if (reg_rd_en) begin
                reg_rdata <= rd_byte;
            end
            if (period_fill) begin
                case (byte_idx)
                    2'd0:    period_stage[7:0]   <= reg_wdata;
                    2'd1:    period_stage[15:8]  <= reg_wdata;
                    default: period_stage[23:16] <= reg_wdata;
                endcase
            end
            if (duty_fill) begin
                case (byte_idx)
                    2'd0:    duty_stage[7:0]   <= reg_wdata;
                    2'd1:    duty_stage[15:8]  <= reg_wdata;
                    default: duty_stage[23:16] <= reg_wdata;
                endcase
            end
            if (period_commit) begin
                period_cmt <= CNT_W'({reg_wdata, period_stage});
            end
            if (btn_step) begin
                level <= (level == LEVEL_MAX) ? LEVEL_W'(1) : level + LEVEL_W'(1);
            end
            // A same-cycle LPC duty commit cancels the pending rescale; the level still advances.
            scale_pend <= btn_step && !duty_commit;
            if (duty_commit) begin
                duty_tgt <= CNT_W'({reg_wdata, duty_stage});
            end else if (scale_pend) begin
                duty_tgt <= scaled;
            end
        end
    end

    bklt_pwm_core #(
        .CNT_W      (CNT_W),
        .RAMP_STEP  (RAMP_STEP),
        .PERIOD_RST (PERIOD_RST),
        .DUTY_RST   (DUTY_RST)
    ) u_core (
        .clk        (LPC_CLK33M_GMUX),
        .rst_n      (LPCPLUS_RESET_L),
        .period_tgt (period_cmt),
        .duty_tgt   (duty_tgt),
        .pwm_out    (pwm_out),
        .ramp_busy  (ramp_busy)
    );

endmodule

// File: tb/tb_bklt_pwm_ctrl.sv
// tb/tb_bklt_pwm_ctrl.sv - Directed table-driven bench for bklt_pwm_ctrl, expectations follow BKLT_RAMP_EN
module tb_bklt_pwm_ctrl;

    localparam int CNT_W      = 24;
    localparam int LEVEL_W    = 4;
    localparam int PERIOD_RST = 4999;
    localparam int DUTY_RST   = 1000;
    localparam int LEVEL_RST  = 11;
    localparam int RAMP_STEP  = 256;

`ifdef BKLT_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        btn_step;
    logic        pwm_out;
    logic        ramp_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hi_cnt   = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  exp;
    } rd_vec_t;

    typedef struct {
        int level;
        int prev_tgt;
        int tgt;
    } btn_vec_t;

    rd_vec_t  rd_tbl[15];
    btn_vec_t btn_tbl[5];

    always #5 clk = ~clk;

    bklt_pwm_ctrl #(
        .CNT_W      (CNT_W),
        .LEVEL_W    (LEVEL_W),
        .PERIOD_RST (PERIOD_RST),
        .DUTY_RST   (DUTY_RST),
        .LEVEL_RST  (LEVEL_RST),
        .RAMP_STEP  (RAMP_STEP)
    ) dut (
        .LPC_CLK33M_GMUX (clk),
        .LPCPLUS_RESET_L (rst_n),
        .reg_wr_en       (reg_wr_en),
        .reg_rd_en       (reg_rd_en),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .btn_step        (btn_step),
        .pwm_out         (pwm_out),
        .ramp_busy       (ramp_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pwm_out === 1'b1) hi_cnt++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        reg_wr_en = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        tick();
        reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [7:0] data);
        reg_rd_en = 1'b1;
        reg_addr  = addr;
        tick();
        reg_rd_en = 1'b0;
        data      = reg_rdata;
    endtask

    task automatic wr_duty(input logic [31:0] v);
        wr(16'h0774, v[7:0]);
        wr(16'h0775, v[15:8]);
        wr(16'h0776, v[23:16]);
        wr(16'h0777, v[31:24]);
    endtask

    initial begin
        logic [7:0] d;

        rd_tbl[0]  = '{16'h0704, 8'd1};
        rd_tbl[1]  = '{16'h0705, 8'd9};
        rd_tbl[2]  = '{16'h0706, 8'd37};
        rd_tbl[3]  = '{16'h0707, 8'h00};
        rd_tbl[4]  = '{16'h0770, 8'h87};
        rd_tbl[5]  = '{16'h0771, 8'h13};
        rd_tbl[6]  = '{16'h0772, 8'h00};
        rd_tbl[7]  = '{16'h0773, 8'h00};
        rd_tbl[8]  = '{16'h0774, 8'hE8};
        rd_tbl[9]  = '{16'h0775, 8'h03};
        rd_tbl[10] = '{16'h0776, 8'h00};
        rd_tbl[11] = '{16'h0777, 8'h00};
        rd_tbl[12] = '{16'h0778, 8'h16};
        rd_tbl[13] = '{16'h0779, 8'h00};
        rd_tbl[14] = '{16'h0000, 8'h00};

        btn_tbl[0] = '{12, 50, 75};
        btn_tbl[1] = '{13, 75, 81};
        btn_tbl[2] = '{14, 81, 87};
        btn_tbl[3] = '{15, 87, 93};
        btn_tbl[4] = '{1,  93, 6};

        rst_n     = 1'b0;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        reg_addr  = 16'h0;
        reg_wdata = 8'h0;
        btn_step  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_busy", 32'(ramp_busy), 0);
        check("rst_rdata", 32'(reg_rdata), 0);

        rst_n  = 1'b1;
        cyc    = 0;
        hi_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            rd(rd_tbl[i].addr, d);
            check($sformatf("rd_%h", rd_tbl[i].addr), 32'(d), 32'(rd_tbl[i].exp));
        end
        run_to(5000);
        check("win0_high", hi_cnt, DUTY_RST);

        // Duty 0x1000 written mid-period must not touch the current period.
        hi_cnt = 0;
        run_to(7500);
        wr_duty(32'h0000_1000);
        rd(16'h0774, d);
        check("tgt_b0", 32'(d), 32'h00);
        rd(16'h0775, d);
        check("tgt_b1", 32'(d), 32'h10);
        check("busy_after_wr", 32'(ramp_busy), RAMP_ON ? 1 : 0);
        run_to(10000);
        check("win1_high", hi_cnt, 1000);
        hi_cnt = 0;
        run_to(15000);
        check("win2_high", hi_cnt, RAMP_ON ? 1256 : 4096);

        hi_cnt = 0;
        wr(16'h0770, 8'd99);
        wr(16'h0771, 8'd0);
        wr(16'h0772, 8'd0);
        wr(16'h0773, 8'd0);
        wr_duty(32'd50);
        rd(16'h0770, d);
        check("period_b0", 32'(d), 32'd99);
        run_to(20000);
        check("win3_high", hi_cnt, RAMP_ON ? 1512 : 4096);
        hi_cnt = 0;
        run_to(20100);
        check("win4_high", hi_cnt, RAMP_ON ? 100 : 50);
        run_to(20499);
        check("busy_pre_fall", 32'(ramp_busy), RAMP_ON ? 1 : 0);
        tick();
        check("busy_fall", 32'(ramp_busy), 0);
        hi_cnt = 0;
        run_to(20600);
        check("duty50_high", hi_cnt, 50);

        for (int i = 0; i < 5; i++) begin
            btn_step = 1'b1;
            tick();
            btn_step = 1'b0;
            rd(16'h0774, d);
            check($sformatf("btn%0d_tgt_1cyc", i), 32'(d), btn_tbl[i].prev_tgt);
            rd(16'h0774, d);
            check($sformatf("btn%0d_tgt_2cyc", i), 32'(d), btn_tbl[i].tgt);
            rd(16'h0778, d);
            check($sformatf("btn%0d_level", i), 32'(d[7:1]), btn_tbl[i].level);
        end

        wr_duty(32'd200);
        repeat (300) tick();
        hi_cnt = 0;
        repeat (100) tick();
        check("duty200_high", hi_cnt, 100);
        wr_duty(32'd0);
        repeat (300) tick();
        hi_cnt = 0;
        repeat (100) tick();
        check("duty0_high", hi_cnt, 0);

        // Button and LPC byte-3 commit in the same cycle: LPC wins, level advances.
        wr(16'h0774, 8'h34);
        wr(16'h0775, 8'h12);
        wr(16'h0776, 8'h56);
        reg_wr_en = 1'b1;
        reg_addr  = 16'h0777;
        reg_wdata = 8'hFF;
        btn_step  = 1'b1;
        tick();
        reg_wr_en = 1'b0;
        btn_step  = 1'b0;
        repeat (2) tick();
        rd(16'h0774, d);
        check("conf_b0", 32'(d), 32'h34);
        rd(16'h0775, d);
        check("conf_b1", 32'(d), 32'h12);
        rd(16'h0776, d);
        check("conf_b2", 32'(d), 32'h56);
        rd(16'h0777, d);
        check("conf_b3_trunc", 32'(d), 32'h00);
        rd(16'h0778, d);
        check("conf_level", 32'(d[7:1]), 2);

        repeat (300) tick();
        check("pre_rst_pwm", 32'(pwm_out), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 0);
        check("async_rst_busy", 32'(ramp_busy), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        cyc    = 0;
        hi_cnt = 0;
        run_to(1000);
        check("restart_high", hi_cnt, 1000);
        hi_cnt = 0;
        run_to(1100);
        check("restart_low", hi_cnt, 0);
        rd(16'h0778, d);
        check("restart_status", 32'(d), 32'h16);
        wr(16'h0777, 8'h00);
        rd(16'h0774, d);
        check("stage_cleared_b0", 32'(d), 32'h00);
        rd(16'h0776, d);
        check("stage_cleared_b2", 32'(d), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
